unified_mem_arbiter: RTL and testbench

Arbitrates a single unified main-memory port between the instruction-fetch miss path and the data-memory access path of the 5-stage pipeline. Each side issues one line-sized transaction at a time. The arbiter latches the winner's request, holds it stable on the memory port until memory completes, and returns read data with a one-cycle ready pulse. Data-side requests have priority, but a bounded starvation counter guarantees the fetch side makes progress.

---
 rtl/unified_mem_arbiter.sv | 119 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one unified memory port between the fetch miss path (I) and
// the data access path (D); D has priority, bounded by a starvation counter.
module unified_mem_arbiter #(
  parameter int LINE_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [15:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       grant_d, grant_i;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && (!i_req || starve_cnt < STARVE_LIM)) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: if (mem_ready) state_nxt = RESP;
      RESP:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      if (grant_d) begin
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        owner_d   <= 1'b1;
      end else if (grant_i) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
        owner_d  <= 1'b0;
      end

      if (state == SERVE_I && mem_ready) begin
        mem_en  <= 1'b0;
        i_rdata <= mem_rdata;
        i_ready <= 1'b1;
      end
      if (state == SERVE_D && mem_ready) begin
        mem_en  <= 1'b0;
        d_ready <= 1'b1;
        if (!mem_we) d_rdata <= mem_rdata;
      end

      // Counts D wins over a waiting fetch; any I grant or idle fetch side clears it.
      if (state == IDLE) begin
        if (grant_d && i_req) begin
          if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
        end else if (grant_i || !i_req) begin
          starve_cnt <= '0;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level model and a bench memory.
module tb_unified_mem_arbiter;

  localparam int LW = 64;
  localparam int SM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ready;
  logic [15:0]   i_addr, d_addr, mem_addr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_en, mem_we, busy, owner_d;

  unified_mem_arbiter #(.LINE_W(LW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: starvation count, expected output registers, bench memory.
  int            starve_m;
  logic [LW-1:0] exp_i_rdata, exp_d_rdata, exp_wdata;
  logic [LW-1:0] mem_model [logic [15:0]];

  function automatic logic [LW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] mem_value(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_i_ready"}, i_ready, 0);
    check({tag, "_d_ready"}, d_ready, 0);
    check({tag, "_owner_d"}, owner_d, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_i_ready"}, i_ready, 0);
    check({tag, "_d_ready"}, d_ready, 0);
    check({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
    check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
  endtask

  // Called in an IDLE cycle with at least one request up; runs one full
  // transaction with memory answering in SERVE cycle lat, returns in IDLE.
  task automatic serve_one(input int lat, output logic dut_owner);
    logic          wd, we;
    logic [15:0]   ea;
    logic [LW-1:0] rd;
    wd = d_req && (!i_req || starve_m < SM);
    if (wd) begin
      ea        = d_addr;
      we        = d_we;
      exp_wdata = d_wdata;
      starve_m  = i_req ? ((starve_m < SM) ? starve_m + 1 : starve_m) : 0;
    end else begin
      ea       = i_addr;
      we       = 1'b0;
      starve_m = 0;
    end
    rd = mem_value(ea);
    dut_owner = 1'bx;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == 1) begin
        dut_owner = owner_d;
        // Winner's request fields change after the grant; the port must not follow.
        if (wd) begin
          d_addr = 16'($urandom); d_wdata = rnd64(); d_we = 1'($urandom);
        end else begin
          i_addr = 16'($urandom);
        end
      end
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? rd : rnd64();
      check("serve_busy", busy, 1);
      check("serve_mem_en", mem_en, 1);
      check("serve_owner_d", owner_d, wd);
      check("serve_mem_addr", mem_addr, ea);
      check("serve_mem_we", mem_we, we);
      check("serve_mem_wdata", mem_wdata, exp_wdata);
      check("serve_i_ready", i_ready, 0);
      check("serve_d_ready", d_ready, 0);
    end
    if (we)      mem_model[ea] = exp_wdata;
    else if (wd) exp_d_rdata = rd;
    else         exp_i_rdata = rd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = rnd64();
    check("resp_busy", busy, 1);
    check("resp_mem_en", mem_en, 0);
    check("resp_i_ready", i_ready, !wd);
    check("resp_d_ready", d_ready, wd);
    check("resp_i_rdata", i_rdata, exp_i_rdata);
    check("resp_d_rdata", d_rdata, exp_d_rdata);
    if (wd) d_req = 1'b0;
    else    i_req = 1'b0;
    tick();
    check_idle("post");
  endtask

  logic o;
  bit   pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    starve_m = 0; exp_i_rdata = '0; exp_d_rdata = '0; exp_wdata = '0;

    // Reset values
    repeat (3) tick();
    check_reset_state("rst");
    rst = 1'b0;
    tick();
    check_reset_state("rst_rel");

    // Stray mem_ready while idle
    mem_ready = 1'b1; mem_rdata = rnd64();
    tick();
    check_idle("stray1");
    tick();
    mem_ready = 1'b0;
    check_idle("stray2");

    // I read, memory answers 3 cycles after mem_en first rises
    mem_model[16'h0100] = 64'h1122334455667788;
    i_req = 1'b1; i_addr = 16'h0100;
    serve_one(4, o);
    check("iread_owner", o, 0);
    check("iread_data", i_rdata, 64'h1122334455667788);

    // D write, then read back the same line at minimum latency
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 64'hDEADBEEFCAFEF00D;
    serve_one(3, o);
    check("dwr_owner", o, 1);
    check("dwr_held_wdata", mem_wdata, 64'hDEADBEEFCAFEF00D);
    check("dwr_held_addr", mem_addr, 16'h0040);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    serve_one(1, o);
    check("drd_data", d_rdata, 64'hDEADBEEFCAFEF00D);

    // Simultaneous requests: D first, then I
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    serve_one(1, o);
    check("simul_first", o, 1);
    serve_one(2, o);
    check("simul_second", o, 0);

    // Starvation bound with fetch held and data re-requesting immediately
    for (int k = 0; k < 6; k++) begin
      if (!i_req) begin i_req = 1'b1; i_addr = 16'(16'h0400 + k * 16); end
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'(16'h0800 + k * 16); d_wdata = rnd64();
      end
      serve_one(int'($urandom_range(1, 3)), o);
      check("starve_order", o, pat[k]);
    end

    // Reset during SERVE_D, then a late mem_ready
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
    tick();
    check("rstsrv_mem_en", mem_en, 1);
    check("rstsrv_owner", owner_d, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0;
    starve_m = 0; exp_i_rdata = '0; exp_d_rdata = '0; exp_wdata = '0;
    check_reset_state("rstsrv");
    mem_ready = 1'b1; mem_rdata = rnd64();
    tick();
    mem_ready = 1'b0;
    check_idle("rstsrv_late1");
    tick();
    check_idle("rstsrv_late2");

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1'b1; i_addr = 16'($urandom_range(0, 7) << 4);
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom_range(0, 7) << 4);
        d_wdata = rnd64();
      end
      if (i_req || d_req) begin
        serve_one(int'($urandom_range(1, 4)), o);
      end else begin
        if ($urandom_range(0, 1) == 1) begin mem_ready = 1'b1; mem_rdata = rnd64(); end
        tick();
        mem_ready = 1'b0;
        starve_m = 0;
        check_idle("rand_idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
